// File: rtl/quad_pkg.sv
// Shared phase codes, transition classification and the decode helper used by
// the quadrature receiver.
package quad_pkg;

    localparam logic [1:0] PH_00 = 2'b00;
    localparam logic [1:0] PH_01 = 2'b01;
    localparam logic [1:0] PH_11 = 2'b11;
    localparam logic [1:0] PH_10 = 2'b10;

    typedef enum logic [1:0] {
        TR_NONE,
        TR_INC,
        TR_DEC,
        TR_ILLEGAL
    } trans_e;

    function automatic logic [1:0] fwd_next(input logic [1:0] ph);
        case (ph)
            PH_00:   fwd_next = PH_01;
            PH_01:   fwd_next = PH_11;
            PH_11:   fwd_next = PH_10;
            default: fwd_next = PH_00;
        endcase
    endfunction

    // Any change that is neither one step forward nor one step back moved both phases.
    function automatic trans_e decode_trans(input logic [1:0] prev, input logic [1:0] cur);
        if (cur == prev) begin
            return TR_NONE;
        end else if (cur == fwd_next(prev)) begin
            return TR_INC;
        end else if (prev == fwd_next(cur)) begin
            return TR_DEC;
        end else begin
            return TR_ILLEGAL;
        end
    endfunction

endpackage

// File: rtl/quad_filter.sv
// Two-flop synchronizer followed by a level-persistence glitch filter for one
// quadrature phase.
module quad_filter #(
    parameter int FILT_LEN = 3
) (
    input  logic CLK,
    input  logic reset,
    input  logic ce,
    input  logic d_in,
    output logic d_out,
    output logic stable
);

    // The counter only has to reach FILT_LEN-1; the next differing sample accepts.
    localparam int CW = (FILT_LEN < 2) ? 1 : $clog2(FILT_LEN);
    localparam logic [CW-1:0] LAST = CW'((FILT_LEN > 0) ? (FILT_LEN - 1) : 0);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic [1:0]    fill_q, fill_d;
    logic          f_q, f_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d = d_in;
        sync2_d = sync1_q;
        fill_d  = (fill_q == 2'd2) ? fill_q : fill_q + 2'd1;
        f_d     = f_q;
        cnt_d   = cnt_q;
        if (ce) begin
            if (FILT_LEN == 0) begin
                f_d = sync2_q;
            end else if (sync2_q == f_q) begin
                cnt_d = '0;
            end else if (cnt_q == LAST) begin
                f_d   = sync2_q;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            fill_q  <= 2'd0;
            f_q     <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            fill_q  <= fill_d;
            f_q     <= f_d;
            cnt_q   <= cnt_d;
        end
    end

    // Stable once real input has reached the filter and the filter agrees with it.
    assign d_out  = f_q;
    assign stable = (fill_q == 2'd2) && (sync2_q == f_q);

endmodule

// File: rtl/quad_decoder.sv
// Quadrature receiver: filters both phases, primes on the first settled phase,
// then x4-decodes edges into a signed position, step/dir and error reporting.
module quad_decoder
    import quad_pkg::*;
#(
    parameter int FILT_LEN = 3,
    parameter int CNT_W    = 8,
    parameter bit SAT      = 1'b1
) (
    input  logic                    CLK,
    input  logic                    reset,
    input  logic                    ce,
    input  logic                    steerA,
    input  logic                    steerB,
    input  logic                    clear,
    output logic signed [CNT_W-1:0] count,
    output logic                    step,
    output logic                    dir,
    output logic                    err,
    output logic [7:0]              err_cnt
);

    localparam logic signed [CNT_W-1:0] CNT_MAX = {1'b0, {(CNT_W-1){1'b1}}};
    localparam logic signed [CNT_W-1:0] CNT_MIN = {1'b1, {(CNT_W-1){1'b0}}};

    logic       f_a, f_b;
    logic       stable_a, stable_b;
    logic [1:0] phase;
    trans_e     trans;

    logic [1:0]              pp_q, pp_d;
    logic                    primed_q, primed_d;
    logic signed [CNT_W-1:0] count_q, count_d;
    logic                    step_q, step_d;
    logic                    dir_q, dir_d;
    logic                    err_q, err_d;
    logic [7:0]              err_cnt_q, err_cnt_d;

    quad_filter #(.FILT_LEN(FILT_LEN)) u_filt_a (
        .CLK    (CLK),
        .reset  (reset),
        .ce     (ce),
        .d_in   (steerA),
        .d_out  (f_a),
        .stable (stable_a)
    );

    quad_filter #(.FILT_LEN(FILT_LEN)) u_filt_b (
        .CLK    (CLK),
        .reset  (reset),
        .ce     (ce),
        .d_in   (steerB),
        .d_out  (f_b),
        .stable (stable_b)
    );

    assign phase = {f_a, f_b};

    always_comb begin
        trans     = decode_trans(pp_q, phase);
        pp_d      = pp_q;
        primed_d  = primed_q;
        count_d   = count_q;
        dir_d     = dir_q;
        step_d    = 1'b0;
        err_d     = 1'b0;
        err_cnt_d = err_cnt_q;
        if (ce) begin
            if (!primed_q) begin
                if (stable_a && stable_b) begin
                    pp_d     = phase;
                    primed_d = 1'b1;
                end
            end else begin
                pp_d = phase;
                unique case (trans)
                    TR_INC: begin
                        step_d = 1'b1;
                        dir_d  = 1'b1;
                        if (!(SAT && (count_q == CNT_MAX))) begin
                            count_d = count_q + CNT_W'(1);
                        end
                    end
                    TR_DEC: begin
                        step_d = 1'b1;
                        dir_d  = 1'b0;
                        if (!(SAT && (count_q == CNT_MIN))) begin
                            count_d = count_q - CNT_W'(1);
                        end
                    end
                    TR_ILLEGAL: begin
                        err_d = 1'b1;
                        if (err_cnt_q != 8'hFF) begin
                            err_cnt_d = err_cnt_q + 8'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
        // Clear overrides the counters only; edge reporting and phase tracking proceed.
        if (clear) begin
            count_d   = '0;
            err_cnt_d = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            pp_q      <= PH_00;
            primed_q  <= 1'b0;
            count_q   <= '0;
            step_q    <= 1'b0;
            dir_q     <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= 8'd0;
        end else begin
            pp_q      <= pp_d;
            primed_q  <= primed_d;
            count_q   <= count_d;
            step_q    <= step_d;
            dir_q     <= dir_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign count   = count_q;
    assign step    = step_q;
    assign dir     = dir_q;
    assign err     = err_q;
    assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Scoreboard bench for quad_decoder: a saturating and a wrapping instance share
// the same directed phase sequence; a monitor checks every step/err pulse.
module tb_quad_decoder;

    localparam int K_NONE = 0;
    localparam int K_INC  = 1;
    localparam int K_DEC  = 2;
    localparam int K_ERR  = 3;

    typedef struct {
        bit is_err;
        int cnt_sat;
        int cnt_wrap;
        bit dir;
        int err_cnt;
    } exp_t;

    logic clk = 1'b0;
    logic reset, ce, steer_a, steer_b, clear;
    logic signed [7:0] count, count_w;
    logic step, dir, err, step_w, dir_w, err_w;
    logic [7:0] err_cnt, err_cnt_w;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   m_sat = 0, m_wrap = 0, m_err = 0;
    bit   m_dir = 1'b0;
    logic [1:0] cur_ph;

    quad_decoder #(.FILT_LEN(3), .CNT_W(8), .SAT(1'b1)) dut (
        .CLK(clk), .reset(reset), .ce(ce), .steerA(steer_a), .steerB(steer_b),
        .clear(clear), .count(count), .step(step), .dir(dir), .err(err), .err_cnt(err_cnt)
    );

    quad_decoder #(.FILT_LEN(3), .CNT_W(8), .SAT(1'b0)) dut_wrap (
        .CLK(clk), .reset(reset), .ce(ce), .steerA(steer_a), .steerB(steer_b),
        .clear(clear), .count(count_w), .step(step_w), .dir(dir_w), .err(err_w), .err_cnt(err_cnt_w)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic logic [1:0] next_fwd(input logic [1:0] ph);
        case (ph)
            2'b00:   return 2'b01;
            2'b01:   return 2'b11;
            2'b11:   return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    task automatic expect_event(input int kind, input bit clr_hit);
        exp_t e;
        case (kind)
            K_INC: begin
                if (m_sat < 127) m_sat++;
                m_wrap = (m_wrap == 127) ? -128 : m_wrap + 1;
                m_dir  = 1'b1;
            end
            K_DEC: begin
                if (m_sat > -128) m_sat--;
                m_wrap = (m_wrap == -128) ? 127 : m_wrap - 1;
                m_dir  = 1'b0;
            end
            K_ERR: if (m_err < 255) m_err++;
            default: ;
        endcase
        if (clr_hit) begin
            m_sat  = 0;
            m_wrap = 0;
            m_err  = 0;
        end
        if (kind != K_NONE) begin
            e.is_err   = (kind == K_ERR);
            e.cnt_sat  = m_sat;
            e.cnt_wrap = m_wrap;
            e.dir      = m_dir;
            e.err_cnt  = m_err;
            exp_q.push_back(e);
        end
    endtask

    // Called right after a negedge; the decoded edge lands on the 6th posedge after.
    task automatic apply_stimulus(input logic [1:0] ph, input int kind, input int hold, input bit clr_hit);
        expect_event(kind, clr_hit);
        {steer_a, steer_b} = ph;
        cur_ph = ph;
        if (clr_hit) begin
            repeat (5) @(negedge clk);
            clear = 1'b1;
            @(negedge clk);
            clear = 1'b0;
            repeat (hold - 6) @(negedge clk);
        end else begin
            repeat (hold) @(negedge clk);
        end
    endtask

    // Monitor: every pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && (step || err)) begin
            exp_t e;
            check_output("step_err_exclusive", int'(step && err), 0);
            if (exp_q.size() == 0) begin
                check_output("unexpected_pulse", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check_output("pulse_is_err", int'(err), int'(e.is_err));
                check_output("pulse_is_step", int'(step), int'(!e.is_err));
                check_output("count_sat", int'(count), e.cnt_sat);
                check_output("count_wrap", int'(count_w), e.cnt_wrap);
                check_output("dir", int'(dir), int'(e.dir));
                check_output("err_cnt", int'(err_cnt), e.err_cnt);
                check_output("wrap_pulse_align", int'({step_w, err_w}), int'({step, err}));
                check_output("wrap_dir", int'(dir_w), int'(e.dir));
                check_output("wrap_err_cnt", int'(err_cnt_w), e.err_cnt);
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected finish before 1000000");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        bit saw;
        reset = 1'b1; ce = 1'b1; clear = 1'b0;
        steer_a = 1'b1; steer_b = 1'b1; cur_ph = 2'b11;
        repeat (3) @(negedge clk);
        check_output("reset_count", int'(count), 0);
        check_output("reset_step", int'(step), 0);
        check_output("reset_dir", int'(dir), 0);
        check_output("reset_err", int'(err), 0);
        check_output("reset_err_cnt", int'(err_cnt), 0);
        reset = 1'b0;

        // Idle at 11 must prime silently.
        repeat (20) @(negedge clk);
        check_output("prime_count", int'(count), 0);
        check_output("prime_err_cnt", int'(err_cnt), 0);

        // Re-prime at 00 via a mid-run reset.
        reset = 1'b1;
        {steer_a, steer_b} = 2'b00; cur_ph = 2'b00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);

        // Forward sequence with first-edge latency measurement.
        expect_event(K_INC, 1'b0);
        {steer_a, steer_b} = 2'b01; cur_ph = 2'b01;
        lat = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (step && lat == 0) lat = i;
        end
        check_output("first_step_latency", lat, 6);
        apply_stimulus(2'b11, K_INC, 8, 1'b0);
        apply_stimulus(2'b10, K_INC, 8, 1'b0);
        apply_stimulus(2'b00, K_INC, 8, 1'b0);
        check_output("fwd_count", int'(count), 4);
        check_output("fwd_dir", int'(dir), 1);

        apply_stimulus(2'b10, K_DEC, 8, 1'b0);
        check_output("rev_count", int'(count), 3);
        check_output("rev_dir", int'(dir), 0);
        apply_stimulus(2'b00, K_INC, 8, 1'b0);

        // Two-cycle glitch on B is rejected, then a real edge is taken.
        steer_b = 1'b1;
        repeat (2) @(negedge clk);
        steer_b = 1'b0;
        repeat (8) @(negedge clk);
        check_output("glitch_count", int'(count), 4);
        apply_stimulus(2'b01, K_INC, 8, 1'b0);
        check_output("post_glitch_count", int'(count), 5);

        // Clear landing on the decode edge wins for count only.
        apply_stimulus(2'b11, K_INC, 8, 1'b1);
        check_output("clear_hit_count", int'(count), 0);
        apply_stimulus(2'b10, K_INC, 8, 1'b0);
        check_output("after_clear_count", int'(count), 1);

        // Illegal jump, then resync from 11.
        apply_stimulus(2'b00, K_INC, 8, 1'b0);
        apply_stimulus(2'b11, K_ERR, 8, 1'b0);
        check_output("illegal_err_cnt", int'(err_cnt), 1);
        check_output("illegal_count", int'(count), 2);
        apply_stimulus(2'b10, K_INC, 8, 1'b0);
        check_output("resync_count", int'(count), 3);

        // With ce low nothing advances.
        ce = 1'b0;
        expect_event(K_INC, 1'b0);
        {steer_a, steer_b} = 2'b00; cur_ph = 2'b00;
        saw = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (step || err) saw = 1'b1;
        end
        check_output("ce_low_no_pulse", int'(saw), 0);
        ce = 1'b1;
        repeat (8) @(negedge clk);
        check_output("ce_resume_count", int'(count), 4);

        // Plain clear pulse, then run past both counter limits.
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        expect_event(K_NONE, 1'b1);
        @(negedge clk);
        check_output("clear_count", int'(count), 0);
        check_output("clear_err_cnt", int'(err_cnt), 0);
        for (int i = 0; i < 130; i++) begin
            apply_stimulus(next_fwd(cur_ph), K_INC, 6, 1'b0);
            if (i == 127) check_output("wrap_at_128", int'(count_w), -128);
        end
        repeat (4) @(negedge clk);
        check_output("sat_hold", int'(count), 127);
        check_output("wrap_final", int'(count_w), -126);
        apply_stimulus(2'b01, K_DEC, 8, 1'b0);
        check_output("sat_rev", int'(count), 126);

        repeat (20) @(negedge clk);
        check_output("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
